adder_1bit_m: RTL and testbench



---
 rtl/adder_1bit_m_pkg.sv | 12 +
 rtl/adder_1bit_m_cell.sv | 15 +
 rtl/adder_1bit_m.sv | 74 +++++++
 tb/tb_adder_1bit_m.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_1bit_m_pkg.sv
// Shared constants and helpers for the adder_1bit_m leaf arithmetic cell.
package adder_1bit_m_pkg;

  localparam logic RST_F_Q  = 1'b0;
  localparam logic RST_C1_Q = 1'b0;
  localparam logic RST_SER  = 1'b0;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/adder_1bit_m_cell.sv
// Purely combinational full-adder cell: S = A ^ B ^ CI, CO = majority(A, B, CI).
module full_adder_cell
  import adder_1bit_m_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = maj(A, B, CI);

endmodule

// File: rtl/adder_1bit_m.sv
// 1-bit full adder with combinational and registered outputs; the bit-serial
// carry loop is present only when ADDER_1BIT_M_SERIAL_EN is defined.
module adder_1bit_m
  import adder_1bit_m_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C0,
  input  logic en,
  input  logic ser_first,
  output logic F,
  output logic C1,
  output logic F_q,
  output logic C1_q,
  output logic SER_F,
  output logic SER_C
);

  full_adder_cell u_comb (
    .A  (A),
    .B  (B),
    .CI (C0),
    .S  (F),
    .CO (C1)
  );

  // NOTE: registers use non-blocking assignments and an asynchronous active-low
  // clear so outputs drop the moment rst_n falls, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q  <= RST_F_Q;
      C1_q <= RST_C1_Q;
    end else if (en) begin
      F_q  <= F;
      C1_q <= C1;
    end
  end

`ifdef ADDER_1BIT_M_SERIAL_EN
  logic ci;
  logic ser_s;
  logic ser_co;

  // The LSB of a word takes its carry from C0; any stored carry is discarded.
  assign ci = ser_first ? C0 : SER_C;

  full_adder_cell u_ser (
    .A  (A),
    .B  (B),
    .CI (ci),
    .S  (ser_s),
    .CO (ser_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SER_F <= RST_SER;
      SER_C <= RST_SER;
    end else if (en) begin
      SER_F <= ser_s;
      SER_C <= ser_co;
    end
  end
`else
  logic unused_ser_first;
  assign unused_ser_first = ser_first;

  assign SER_F = RST_SER;
  assign SER_C = RST_SER;
`endif

endmodule

// File: tb/tb_adder_1bit_m.sv
// Self-checking bench for adder_1bit_m: directed steps followed by random
// vectors checked against an arithmetic reference model.
module tb_adder_1bit_m;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C0, en, ser_first;
  logic F, C1, F_q, C1_q, SER_F, SER_C;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic m_fq, m_c1q, m_serf, m_serc;

  adder_1bit_m dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C0        (C0),
    .en        (en),
    .ser_first (ser_first),
    .F         (F),
    .C1        (C1),
    .F_q       (F_q),
    .C1_q      (C1_q),
    .SER_F     (SER_F),
    .SER_C     (SER_C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic e,
                       input logic sf);
    A = a; B = b; C0 = c; en = e; ser_first = sf;
  endtask

  // Serial outputs are expected to stay at zero when the serial loop is compiled out.
  function automatic logic ser_exp(input logic v);
`ifdef ADDER_1BIT_M_SERIAL_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  initial begin
    int sum;
    logic ci;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    check("reset_F_q", F_q, 1'b0);
    check("reset_C1_q", C1_q, 1'b0);
    check("reset_SER_F", SER_F, 1'b0);
    check("reset_SER_C", SER_C, 1'b0);

    // Combinational sweep: {C1,F} is the two-bit arithmetic sum of the inputs.
    for (int i = 0; i < 8; i++) begin
      A = i[2]; B = i[1]; C0 = i[0];
      #100;
      sum = int'(A) + int'(B) + int'(C0);
      check($sformatf("comb_F_%0d", i), F, sum[0]);
      check($sformatf("comb_C1_%0d", i), C1, sum[1]);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Register enable and hold
    drive(1, 1, 0, 1, 0);
    tick();
    check("en_F_q", F_q, 1'b0);
    check("en_C1_q", C1_q, 1'b1);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("hold_F_q", F_q, 1'b0);
    check("hold_C1_q", C1_q, 1'b1);

    // Load ones, then assert reset mid-cycle
    drive(1, 1, 1, 1, 1);
    tick();
    check("ones_F_q", F_q, 1'b1);
    check("ones_SER_C", SER_C, ser_exp(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_F_q", F_q, 1'b0);
    check("async_rst_C1_q", C1_q, 1'b0);
    check("async_rst_SER_F", SER_F, 1'b0);
    check("async_rst_SER_C", SER_C, 1'b0);
    check("async_rst_F", F, 1'b1);
    check("async_rst_C1", C1, 1'b1);
    tick();
    check("rst_held_F_q", F_q, 1'b0);
    check("rst_held_SER_C", SER_C, 1'b0);
    rst_n = 1'b1;

    // Serial 3 + 1, LSB first
    drive(1, 1, 0, 1, 1);
    tick();
    check("ser0_SER_F", SER_F, ser_exp(1'b0));
    check("ser0_SER_C", SER_C, ser_exp(1'b1));
    drive(1, 0, 0, 1, 0);
    tick();
    check("ser1_SER_F", SER_F, ser_exp(1'b0));
    check("ser1_SER_C", SER_C, ser_exp(1'b1));
    drive(0, 0, 0, 1, 0);
    tick();
    check("ser2_SER_F", SER_F, ser_exp(1'b1));
    check("ser2_SER_C", SER_C, ser_exp(1'b0));

    // Serial restart discards a pending carry
    drive(1, 1, 0, 1, 1);
    tick();
    check("restart_pre_SER_C", SER_C, ser_exp(1'b1));
    drive(0, 0, 0, 1, 1);
    tick();
    check("restart_SER_F", SER_F, 1'b0);
    check("restart_SER_C", SER_C, 1'b0);

    // Serial hold with en low
    drive(1, 1, 0, 1, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    check("ser_hold_SER_C", SER_C, ser_exp(1'b1));
    check("ser_hold_SER_F", SER_F, ser_exp(1'b0));

    // Resynchronise model and DUT through reset, then run random vectors.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_fq = 1'b0; m_c1q = 1'b0; m_serf = 1'b0; m_serc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0));
      #1;
      sum = int'(A) + int'(B) + int'(C0);
      check("rnd_F", F, sum[0]);
      check("rnd_C1", C1, sum[1]);
      if (en) begin
        m_fq  = sum[0];
        m_c1q = sum[1];
        ci = ser_first ? C0 : m_serc;
        sum = int'(A) + int'(B) + int'(ci);
        m_serf = ser_exp(sum[0]);
        m_serc = ser_exp(sum[1]);
      end
      tick();
      check("rnd_F_q", F_q, m_fq);
      check("rnd_C1_q", C1_q, m_c1q);
      check("rnd_SER_F", SER_F, m_serf);
      check("rnd_SER_C", SER_C, m_serc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
